// File: rtl/seq_alu.sv
// Multi-cycle ALU: add/sub, unsigned shift-add multiply, signed restoring divide.
// start/busy/done handshake; result, cout and div0 are registered and held between ops.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_a,
    input  logic [WIDTH-1:0]   data_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               cout,
    output logic               div0
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDSUB = 3'd1,
        S_MUL    = 3'd2,
        S_DIV    = 3'd3,
        S_FIX    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic               sub_q;
    logic               neg_q;
    logic [WIDTH-1:0]   a_q;      // add/sub operand A, or the divide quotient shift register
    logic [WIDTH-1:0]   b_q;      // operand B, multiplier (shifted right), or divisor magnitude
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic [CW-1:0]      cnt_q;

    logic [WIDTH-1:0]   in_a, in_b;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_sub, rem_next, quo_next;
    logic [2*WIDTH-1:0] quo_ext;

    logic               load_res;
    logic [2*WIDTH-1:0] res_d;
    logic               cout_d, div0_d;

    // Divide works on magnitudes; -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        in_a = data_a;
        in_b = data_b;
        if (op == OP_DIV) begin
            if (data_a[WIDTH-1]) in_a = -data_a;
            if (data_b[WIDTH-1]) in_b = -data_b;
        end
    end

    always_comb begin
        add_sum   = {1'b0, a_q} + {1'b0, (sub_q ? ~b_q : b_q)} + {{WIDTH{1'b0}}, sub_q};
        mul_sum   = acc_q + (b_q[0] ? mcand_q : '0);
        rem_shift = {rem_q, a_q[WIDTH-1]};
        div_ge    = rem_shift >= {1'b0, b_q};
        rem_sub   = rem_shift[WIDTH-1:0] - b_q;
        rem_next  = div_ge ? rem_sub : rem_shift[WIDTH-1:0];
        quo_next  = {a_q[WIDTH-2:0], div_ge};
        quo_ext   = {{WIDTH{1'b0}}, a_q};
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
        res_d    = '0;
        cout_d   = 1'b0;
        div0_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_ADD, OP_SUB: state_d = S_ADDSUB;
                        OP_MUL:         state_d = S_MUL;
                        default:        state_d = S_DIV;
                    endcase
                end
            end
            S_ADDSUB: begin
                load_res = 1'b1;
                res_d    = {{WIDTH{1'b0}}, add_sum[WIDTH-1:0]};
                cout_d   = add_sum[WIDTH];
                state_d  = S_DONE;
            end
            S_MUL: begin
                if (cnt_q == LAST) begin
                    load_res = 1'b1;
                    res_d    = mul_sum;
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                if (b_q == '0) begin
                    load_res = 1'b1;
                    res_d    = {{(2*WIDTH-1){1'b1}}, 1'b0};
                    div0_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (cnt_q == LAST) begin
                    state_d  = S_FIX;
                end
            end
            S_FIX: begin
                load_res = 1'b1;
                res_d    = neg_q ? -quo_ext : quo_ext;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q   <= 1'b0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            result  <= '0;
            cout    <= 1'b0;
            div0    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sub_q   <= (op == OP_SUB);
                        neg_q   <= (op == OP_DIV) && (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
                        a_q     <= in_a;
                        b_q     <= in_b;
                        mcand_q <= {{WIDTH{1'b0}}, data_a};
                        acc_q   <= '0;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                S_MUL: begin
                    acc_q   <= mul_sum;
                    mcand_q <= mcand_q << 1;
                    b_q     <= b_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                end
                S_DIV: begin
                    a_q   <= quo_next;
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
            if (load_res) begin
                result <= res_d;
                cout   <= cout_d;
                div0   <= div0_d;
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed self-checking bench for seq_alu at WIDTH=8 and WIDTH=16,
// compared against an arithmetic reference model.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [1:0]  op8, op16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, cout8, div08;
    logic        busy16, done16, cout16, div016;
    logic [15:0] res8;
    logic [31:0] res16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .data_a(a8), .data_b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .div0(div08)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .data_a(a16), .data_b(b16),
        .busy(busy16), .done(done16), .result(res16), .cout(cout16), .div0(div016)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit w16, input logic s, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        if (w16) begin
            start16 = s; op16 = o; a16 = a[15:0]; b16 = b[15:0];
        end else begin
            start8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    function automatic logic get_busy(input bit w16);
        return w16 ? busy16 : busy8;
    endfunction
    function automatic logic get_done(input bit w16);
        return w16 ? done16 : done8;
    endfunction
    function automatic logic get_cout(input bit w16);
        return w16 ? cout16 : cout8;
    endfunction
    function automatic logic get_div0(input bit w16);
        return w16 ? div016 : div08;
    endfunction
    function automatic logic [63:0] get_res(input bit w16);
        return w16 ? {32'b0, res16} : {48'b0, res8};
    endfunction

    // Reference: plain integer arithmetic on the operand values, plus the latency table.
    task automatic model(input int w, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output logic c, output logic d, output int lat);
        longint ua, ub, sa, sb, mask, mask2, half;
        mask  = (longint'(1) << w) - 1;
        mask2 = (longint'(1) << (2 * w)) - 1;
        half  = longint'(1) << (w - 1);
        ua    = longint'(a) & mask;
        ub    = longint'(b) & mask;
        c     = 1'b0;
        d     = 1'b0;
        lat   = 2;
        case (o)
            2'b00: begin
                res = 64'((ua + ub) & mask);
                c   = ((ua + ub) >> w) != 0;
            end
            2'b01: begin
                res = 64'((ua - ub) & mask);
                c   = (ua >= ub);
            end
            2'b10: begin
                res = 64'(ua * ub);
                lat = w + 1;
            end
            default: begin
                if (ub == 0) begin
                    res = 64'(mask2 - 1);
                    d   = 1'b1;
                end else begin
                    sa  = (ua >= half) ? ua - (mask + 1) : ua;
                    sb  = (ub >= half) ? ub - (mask + 1) : ub;
                    res = 64'((sa / sb) & mask2);
                    lat = w + 2;
                end
            end
        endcase
    endtask

    // Issues one op, follows it cycle by cycle (bounded), checks latency, busy span and outputs.
    // With poke set, a different start is pulsed while busy and must be ignored.
    task automatic run_op(input bit w16, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        string       names[4] = '{"add", "sub", "mul", "div"};
        string       tag;
        int          w, lat, exp_lat;
        bit          busy_ok;
        logic [63:0] exp_res;
        logic        exp_c, exp_d;
        w = w16 ? 16 : 8;
        model(w, o, a, b, exp_res, exp_c, exp_d, exp_lat);
        tag = $sformatf("%s w%0d %0h,%0h", names[o], w, a, b);
        @(negedge clk);
        drive(w16, 1'b1, o, a, b);
        @(negedge clk);
        drive(w16, 1'b0, ~o, ~a, ~b);
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            if (poke && k == 3) drive(w16, 1'b1, 2'b00, 32'h1, 32'h1);
            if (poke && k == 4) drive(w16, 1'b0, 2'b01, 32'h3, 32'h3);
            if (!get_busy(w16)) busy_ok = 1'b0;
            if (get_done(w16)) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        drive(w16, 1'b0, 2'b00, 32'h0, 32'h0);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, get_res(w16), exp_res);
        check({tag, " cout"}, 64'(get_cout(w16)), 64'(exp_c));
        check({tag, " div0"}, 64'(get_div0(w16)), 64'(exp_d));
        check({tag, " busy span"}, 64'(busy_ok), 64'(1));
        @(negedge clk);
        check({tag, " done pulse"}, 64'(get_done(w16)), 64'(0));
        check({tag, " idle busy"}, 64'(get_busy(w16)), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          w16, saw_done;
        logic [1:0]  o;
        logic [31:0] a, b;

        rst = 1'b1;
        drive(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 2'b00, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("reset busy8", 64'(busy8), 64'(0));
        check("reset done8", 64'(done8), 64'(0));
        check("reset res8", 64'(res8), 64'(0));
        check("reset cout8", 64'(cout8), 64'(0));
        check("reset div0_8", 64'(div08), 64'(0));
        check("reset busy16", 64'(busy16), 64'(0));
        check("reset res16", 64'(res16), 64'(0));
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        rst = 1'b0;

        // Directed WIDTH=8 cases with literal expected results.
        run_op(1'b0, 2'b00, 32'hFF, 32'h01, 1'b0);
        check("add ff+01 lit", 64'(res8), 64'h0000);
        check("add ff+01 carry lit", 64'(cout8), 64'(1));
        run_op(1'b0, 2'b01, 32'h05, 32'h07, 1'b0);
        check("sub 05-07 lit", 64'(res8), 64'h00FE);
        run_op(1'b0, 2'b01, 32'h07, 32'h07, 1'b0);
        run_op(1'b0, 2'b10, 32'hFF, 32'hFF, 1'b0);
        check("mul ff*ff lit", 64'(res8), 64'hFE01);
        run_op(1'b0, 2'b10, 32'h00, 32'h5A, 1'b0);
        run_op(1'b0, 2'b11, 32'hF9, 32'h02, 1'b0);
        check("div f9/02 lit", 64'(res8), 64'hFFFD);
        run_op(1'b0, 2'b11, 32'h80, 32'hFF, 1'b0);
        check("div 80/ff lit", 64'(res8), 64'h0080);
        run_op(1'b0, 2'b11, 32'h07, 32'hFE, 1'b0);
        check("div 07/fe lit", 64'(res8), 64'hFFFD);
        run_op(1'b0, 2'b11, 32'h12, 32'h00, 1'b0);
        check("div 12/00 lit", 64'(res8), 64'hFFFE);
        run_op(1'b0, 2'b00, 32'h30, 32'h12, 1'b0);
        run_op(1'b0, 2'b10, 32'h0D, 32'h0B, 1'b1);
        run_op(1'b0, 2'b11, 32'h64, 32'hF9, 1'b1);

        // start held through the done cycle is taken only in the following idle cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b00, 32'h10, 32'h20);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check("b2b first done", 64'(done8), 64'(1));
        drive(1'b0, 1'b1, 2'b00, 32'h03, 32'h04);
        @(negedge clk);
        check("b2b ignored in done", 64'(busy8), 64'(0));
        @(negedge clk);
        check("b2b accepted in idle", 64'(busy8), 64'(1));
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check("b2b second done", 64'(done8), 64'(1));
        check("b2b second result", 64'(res8), 64'h0007);

        // Reset in the middle of a multiply: outputs clear, no done follows.
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b10, 32'hFF, 32'hFF);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-mul reset busy", 64'(busy8), 64'(0));
        check("mid-mul reset done", 64'(done8), 64'(0));
        check("mid-mul reset result", 64'(res8), 64'(0));
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done8 || busy8) saw_done = 1'b1;
            @(negedge clk);
        end
        check("mid-mul reset no done", 64'(saw_done), 64'(0));
        run_op(1'b0, 2'b00, 32'h21, 32'h43, 1'b0);

        // WIDTH=16 corner cases.
        run_op(1'b1, 2'b10, 32'hFFFF, 32'hFFFF, 1'b0);
        check("mul16 ffff*ffff lit", 64'(res16), 64'hFFFE0001);
        run_op(1'b1, 2'b11, 32'h8000, 32'hFFFF, 1'b0);
        check("div16 8000/ffff lit", 64'(res16), 64'h00008000);
        run_op(1'b1, 2'b11, 32'h1234, 32'h0000, 1'b0);
        run_op(1'b1, 2'b01, 32'h0001, 32'h8000, 1'b0);

        // Random ops on both widths, biased toward zero divisors and most-negative dividends.
        for (int i = 0; i < 120; i++) begin
            w16 = 1'($urandom_range(0, 1));
            o   = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'h0;
            if ($urandom_range(0, 7) == 0) a = w16 ? 32'h8000 : 32'h80;
            if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
            run_op(w16, o, a, b, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
